// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcodes, ALUOp values
// and the control bundle latched in DECODE.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    localparam logic [2:0] ALUOP_R   = 3'b010;
    localparam logic [2:0] ALUOP_ADD = 3'b000;
    localparam logic [2:0] ALUOP_LUI = 3'b011;

    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic [2:0] alu_op;
    } ctrl_t;

    function automatic logic op_legal(input logic [5:0] op);
        logic ok;
        case (op)
            OP_RTYPE, OP_ADDI, OP_LUI: ok = 1'b1;
            default:                   ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic ctrl_t decode_op(input logic [5:0] op);
        ctrl_t c;
        c = '0;
        case (op)
            OP_RTYPE: begin
                c.reg_dst = 1'b1;
                c.alu_src = 1'b0;
                c.alu_op  = ALUOP_R;
            end
            OP_ADDI: begin
                c.reg_dst = 1'b0;
                c.alu_src = 1'b1;
                c.alu_op  = ALUOP_ADD;
            end
            OP_LUI: begin
                c.reg_dst = 1'b0;
                c.alu_src = 1'b1;
                c.alu_op  = ALUOP_LUI;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Fetch handshake and datapath control bundle between the controller (master)
// and the instruction memory / datapath (slave).
interface multicycle_ctrl_if;
    logic       imem_req_o;
    logic       imem_ack_i;
    logic [5:0] ir_op_i;
    logic       pc_we_o;
    logic       ir_we_o;
    logic       reg_dst_o;
    logic       alu_src_o;
    logic [2:0] alu_op_o;
    logic       reg_write_o;

    modport master (
        output imem_req_o, pc_we_o, ir_we_o, reg_dst_o, alu_src_o, alu_op_o, reg_write_o,
        input  imem_ack_i, ir_op_i
    );

    modport slave (
        input  imem_req_o, pc_we_o, ir_we_o, reg_dst_o, alu_src_o, alu_op_o, reg_write_o,
        output imem_ack_i, ir_op_i
    );
endinterface

// File: rtl/multicycle_ctrl_watchdog.sv
// Counts FETCH cycles without an ack; expired_o is high on the last allowed cycle.
module fetch_watchdog #(
    parameter int FETCH_TIMEOUT = 16,
    parameter int TMO_W         = 5
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic cnt_en_i,
    input  logic clr_i,
    output logic expired_o
);

    localparam logic [TMO_W-1:0] LIMIT = TMO_W'(FETCH_TIMEOUT - 1);

    logic [TMO_W-1:0] cnt_q;
    logic [TMO_W-1:0] cnt_d;

    // next count: clear has priority over increment
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (cnt_en_i) begin
            cnt_d = cnt_q + TMO_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // count register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == LIMIT);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU controller: FETCH/DECODE/EXEC/WB sequencing with a guarded
// req/ack instruction fetch, latched decode controls and a retired-instruction count.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int CNT_W         = 32,
    parameter int FETCH_TIMEOUT = 16,
    parameter int TMO_W         = 5
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                run_i,
    multicycle_ctrl_if.master   bus,
    output logic                retired_o,
    output logic [CNT_W-1:0]    instr_cnt_o,
    output logic                illegal_o,
    output logic                fetch_err_o,
    output logic [2:0]          state_o
);

    state_e           state_q, state_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic             reg_write_q, reg_write_d;
    logic             retired_q, retired_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             illegal_q, illegal_d;
    logic             fetch_err_q, fetch_err_d;
    logic             req_s;
    logic             fetch_we_s;
    logic             wd_en_s;
    logic             wd_clr_s;
    logic             wd_expired_s;

    fetch_watchdog #(
        .FETCH_TIMEOUT (FETCH_TIMEOUT),
        .TMO_W         (TMO_W)
    ) u_watchdog (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .cnt_en_i  (wd_en_s),
        .clr_i     (wd_clr_s),
        .expired_o (wd_expired_s)
    );

    // next-state, fetch handshake and control latch logic
    always_comb begin
        state_d     = state_q;
        ctrl_d      = ctrl_q;
        cnt_d       = cnt_q;
        illegal_d   = illegal_q;
        fetch_err_d = fetch_err_q;
        req_s       = 1'b0;
        fetch_we_s  = 1'b0;
        wd_en_s     = 1'b0;
        wd_clr_s    = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (run_i) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                req_s    = 1'b1;
                wd_clr_s = 1'b0;
                // an ack on the expiry cycle still completes the fetch
                if (bus.imem_ack_i) begin
                    fetch_we_s = 1'b1;
                    wd_clr_s   = 1'b1;
                    state_d    = S_DECODE;
                end else if (wd_expired_s) begin
                    fetch_err_d = 1'b1;
                    state_d     = S_HALT;
                end else begin
                    wd_en_s = 1'b1;
                end
            end
            S_DECODE: begin
                if (op_legal(bus.ir_op_i)) begin
                    ctrl_d  = decode_op(bus.ir_op_i);
                    state_d = S_EXEC;
                end else begin
                    ctrl_d    = '0;
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
                end
            end
            S_EXEC: begin
                state_d = S_WB;
            end
            S_WB: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (run_i) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // WB strobes are registered from the state being entered
        reg_write_d = (state_d == S_WB);
        retired_d   = (state_d == S_WB);
    end

    // state, controls, strobes, counter and sticky flags
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            ctrl_q      <= '0;
            reg_write_q <= 1'b0;
            retired_q   <= 1'b0;
            cnt_q       <= '0;
            illegal_q   <= 1'b0;
            fetch_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ctrl_q      <= ctrl_d;
            reg_write_q <= reg_write_d;
            retired_q   <= retired_d;
            cnt_q       <= cnt_d;
            illegal_q   <= illegal_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    assign bus.imem_req_o  = req_s;
    assign bus.ir_we_o     = fetch_we_s;
    assign bus.pc_we_o     = fetch_we_s;
    assign bus.reg_dst_o   = ctrl_q.reg_dst;
    assign bus.alu_src_o   = ctrl_q.alu_src;
    assign bus.alu_op_o    = ctrl_q.alu_op;
    assign bus.reg_write_o = reg_write_q;

    assign retired_o   = retired_q;
    assign instr_cnt_o = cnt_q;
    assign illegal_o   = illegal_q;
    assign fetch_err_o = fetch_err_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus queues expected fetch/retire events,
// a negedge monitor pops and compares them as the controller produces them.
module tb_multicycle_ctrl;
    import ctrl_pkg::*;

    localparam int CNT_W = 32;
    localparam int FT    = 16;
    localparam int TMO_W = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             run;
    logic             retired;
    logic [CNT_W-1:0] cnt;
    logic             illegal;
    logic             ferr;
    logic [2:0]       state;

    multicycle_ctrl_if bus_if ();

    multicycle_ctrl #(
        .CNT_W         (CNT_W),
        .FETCH_TIMEOUT (FT),
        .TMO_W         (TMO_W)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .run_i       (run),
        .bus         (bus_if.master),
        .retired_o   (retired),
        .instr_cnt_o (cnt),
        .illegal_o   (illegal),
        .fetch_err_o (ferr),
        .state_o     (state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int               cyc;
        logic             reg_dst;
        logic             alu_src;
        logic [2:0]       alu_op;
        logic [CNT_W-1:0] cnt;
    } ret_t;

    int   fetch_q[$];
    ret_t ret_q[$];
    logic [CNT_W-1:0] exp_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor: compare every fetch strobe and every retire against the scoreboard
    always @(negedge clk) begin : monitor
        ret_t r;
        if (bus_if.ir_we_o || bus_if.pc_we_o) begin
            check("fetch_we_pair", {29'd0, bus_if.ir_we_o, bus_if.pc_we_o, bus_if.imem_req_o}, 32'd7);
            check("fetch_pending", fetch_q.size() != 0, 1);
            if (fetch_q.size() != 0) check("fetch_cycle", cyc, fetch_q.pop_front());
        end
        if (retired || bus_if.reg_write_o) begin
            check("retire_pending", ret_q.size() != 0, 1);
            if (ret_q.size() != 0) begin
                r = ret_q.pop_front();
                check("retire_cycle", cyc, r.cyc);
                check("wb_strobes", {30'd0, bus_if.reg_write_o, retired}, 32'd3);
                check("wb_state", state, 3'd4);
                check("wb_reg_dst", bus_if.reg_dst_o, r.reg_dst);
                check("wb_alu_src", bus_if.alu_src_o, r.alu_src);
                check("wb_alu_op", bus_if.alu_op_o, r.alu_op);
                check("wb_cnt", cnt, r.cnt);
            end
        end
    end

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        run = 1'b0;
        bus_if.imem_ack_i = 1'b0;
        bus_if.ir_op_i = 6'h00;
        next_cyc();
        next_cyc();
        rst = 1'b0;
        exp_cnt = '0;
    endtask

    // called at the start of a FETCH cycle; returns in WB (legal) or DECODE (illegal)
    task automatic issue(input logic [5:0] op, input int w, input logic run_exec, input logic legal,
                         input logic rd, input logic as, input logic [2:0] aop);
        ret_t r;
        fetch_q.push_back(cyc + w);
        if (legal) begin
            r.cyc     = cyc + w + 3;
            r.reg_dst = rd;
            r.alu_src = as;
            r.alu_op  = aop;
            r.cnt     = exp_cnt;
            ret_q.push_back(r);
            exp_cnt = exp_cnt + 32'd1;
        end
        bus_if.imem_ack_i = 1'b0;
        repeat (w) next_cyc();
        bus_if.imem_ack_i = 1'b1;
        bus_if.ir_op_i = op;
        next_cyc();
        bus_if.imem_ack_i = 1'b0;
        if (legal) begin
            next_cyc();
            check("exec_no_write", bus_if.reg_write_o, 1'b0);
            check("exec_ctrl", {27'd0, bus_if.reg_dst_o, bus_if.alu_src_o, bus_if.alu_op_o},
                  {27'd0, rd, as, aop});
            run = run_exec;
            next_cyc();
        end
    endtask

    initial begin
        rst = 1'b1;
        run = 1'b0;
        bus_if.imem_ack_i = 1'b0;
        bus_if.ir_op_i = 6'h00;
        exp_cnt = '0;
        #2;
        check("rst_state", state, 3'd0);
        check("rst_outs", {retired, illegal, ferr, bus_if.imem_req_o, bus_if.reg_write_o}, 5'd0);
        check("rst_cnt", cnt, 32'd0);
        next_cyc();
        next_cyc();
        rst = 1'b0;

        // R-type, zero-wait ack, run dropped during EXEC
        run = 1'b1;
        next_cyc();
        issue(OP_RTYPE, 0, 1'b0, 1'b1, 1'b1, 1'b0, 3'b010);
        next_cyc();
        check("rtype_idle_state", state, 3'd0);
        check("rtype_idle_req", bus_if.imem_req_o, 1'b0);
        check("rtype_cnt", cnt, 32'd1);
        next_cyc();
        check("idle_hold", state, 3'd0);

        // reset pulse between edges while fetching
        run = 1'b1;
        next_cyc();
        next_cyc();
        check("midfetch_req", bus_if.imem_req_o, 1'b1);
        check("midfetch_state", state, 3'd1);
        #1;
        rst = 1'b1;
        run = 1'b0;
        #1;
        check("arst_state", state, 3'd0);
        check("arst_cnt", cnt, 32'd0);
        check("arst_outs", {bus_if.imem_req_o, bus_if.ir_we_o, bus_if.pc_we_o, bus_if.reg_write_o,
                            retired, illegal, ferr}, 7'd0);
        check("arst_ctrl", {bus_if.reg_dst_o, bus_if.alu_src_o, bus_if.alu_op_o}, 5'd0);
        rst = 1'b0;
        exp_cnt = '0;
        next_cyc();
        check("arst_idle", state, 3'd0);

        // ADDI then LUI back-to-back, 3 wait states each
        run = 1'b1;
        next_cyc();
        issue(OP_ADDI, 3, 1'b1, 1'b1, 1'b0, 1'b1, 3'b000);
        next_cyc();
        issue(OP_LUI, 3, 1'b0, 1'b1, 1'b0, 1'b1, 3'b011);
        next_cyc();
        check("b2b_idle", state, 3'd0);
        check("b2b_cnt", cnt, 32'd2);

        // fetch watchdog expiry
        do_reset();
        run = 1'b1;
        next_cyc();
        repeat (FT - 1) next_cyc();
        check("tmo_last_fetch_state", state, 3'd1);
        check("tmo_last_fetch_err", ferr, 1'b0);
        check("tmo_last_fetch_req", bus_if.imem_req_o, 1'b1);
        next_cyc();
        check("tmo_halt_state", state, 3'd5);
        check("tmo_err", ferr, 1'b1);
        check("tmo_req_drop", bus_if.imem_req_o, 1'b0);
        bus_if.imem_ack_i = 1'b1;
        #1;
        check("halt_ack_ignored", {bus_if.ir_we_o, bus_if.pc_we_o}, 2'd0);
        next_cyc();
        bus_if.imem_ack_i = 1'b0;
        repeat (3) next_cyc();
        check("tmo_stay_halt", state, 3'd5);
        check("tmo_err_sticky", ferr, 1'b1);

        // ack on the final allowed fetch cycle wins over expiry
        do_reset();
        run = 1'b1;
        next_cyc();
        issue(OP_RTYPE, FT - 1, 1'b0, 1'b1, 1'b1, 1'b0, 3'b010);
        next_cyc();
        check("lateack_err", ferr, 1'b0);
        check("lateack_idle", state, 3'd0);
        check("lateack_cnt", cnt, 32'd1);

        // LUI then illegal opcode 6'h23
        do_reset();
        run = 1'b1;
        next_cyc();
        issue(OP_LUI, 0, 1'b1, 1'b1, 1'b0, 1'b1, 3'b011);
        next_cyc();
        issue(6'h23, 0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
        next_cyc();
        check("ill_flag", illegal, 1'b1);
        check("ill_state", state, 3'd5);
        check("ill_ctrl_zero", {bus_if.reg_dst_o, bus_if.alu_src_o, bus_if.alu_op_o}, 5'd0);
        check("ill_req", bus_if.imem_req_o, 1'b0);
        repeat (4) next_cyc();
        check("ill_stay_halt", state, 3'd5);
        check("ill_cnt", cnt, 32'd1);
        check("ill_no_ferr", ferr, 1'b0);

        check("fetch_q_drained", fetch_q.size(), 0);
        check("ret_q_drained", ret_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
